// File: rtl/hazard_if.sv
// Decode-to-scoreboard bundle: decoded instruction fields in, pipeline control out.
// d_valid is decode's offer and issue is the acceptance. An instruction enters E only in a cycle where both are high;
// otherwise decode holds it (stall=1) or discards it (squash=1).
interface hazard_if #(
  parameter int REG_W = 4,
  parameter int DEPTH = 3
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic             d_valid;
  logic [REG_W-1:0] d_rs;
  logic             d_rs_used;
  logic [REG_W-1:0] d_rt;
  logic             d_rt_used;
  logic [REG_W-1:0] d_rd;
  logic             d_reg_write;
  logic             d_mem_read;
  logic             d_halt;
  logic             d_branch;
  logic             stall;
  logic             squash;
  logic             issue;
  logic [SEL_W-1:0] fwd_rs_sel;
  logic [SEL_W-1:0] fwd_rt_sel;
  logic             halted;
  logic [1:0]       dbg_state;

  modport master (
    output d_valid, d_rs, d_rs_used, d_rt, d_rt_used, d_rd,
           d_reg_write, d_mem_read, d_halt, d_branch,
    input  stall, squash, issue, fwd_rs_sel, fwd_rt_sel, halted, dbg_state
  );

  modport slave (
    input  d_valid, d_rs, d_rs_used, d_rt, d_rt_used, d_rd,
           d_reg_write, d_mem_read, d_halt, d_branch,
    output stall, squash, issue, fwd_rs_sel, fwd_rt_sel, halted, dbg_state
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode/execute pipeline control: a DEPTH-slot shift scoreboard of in-flight writers.
// It drives forwarding selects, load-use stalls, branch squash and HLT drain sequencing.
module hazard_scoreboard #(
  parameter int REG_W    = 4,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int SQUASH_N = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  hazard_if.slave hz
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [SEL_W-1:0] drain_cnt;
  logic [SEL_W-1:0] drain_cnt_nx;
  logic [1:0]       sq_cnt;

  logic             slot_v  [DEPTH];
  logic [REG_W-1:0] slot_rd [DEPTH];
  logic             slot_wr [DEPTH];
  logic             slot_ld [DEPTH];

  logic             squash_w;
  logic             ev;
  logic             hazard;
  logic             issue_w;
  logic             rs_ld_haz;
  logic             rt_ld_haz;
  logic [SEL_W-1:0] rs_sel;
  logic [SEL_W-1:0] rt_sel;

  // Scan oldest to youngest so the youngest matching producer is the one left standing.
  always_comb begin
    squash_w  = (sq_cnt != 2'd0) && (state != HALTED);
    ev        = hz.d_valid && !squash_w && (state == RUN);
    rs_sel    = '0;
    rt_sel    = '0;
    rs_ld_haz = 1'b0;
    rt_ld_haz = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (slot_v[k] && slot_wr[k] && slot_rd[k] == hz.d_rs &&
          hz.d_rs != '0 && hz.d_rs_used) begin
        rs_sel    = SEL_W'(k + 1);
        rs_ld_haz = slot_ld[k] && (k < LOAD_LAT);
      end
      if (slot_v[k] && slot_wr[k] && slot_rd[k] == hz.d_rt &&
          hz.d_rt != '0 && hz.d_rt_used) begin
        rt_sel    = SEL_W'(k + 1);
        rt_ld_haz = slot_ld[k] && (k < LOAD_LAT);
      end
    end
    hazard  = ev && (rs_ld_haz || rt_ld_haz);
    issue_w = ev && !hazard;
  end

  assign hz.stall      = (state != RUN) || hazard;
  assign hz.squash     = squash_w;
  assign hz.issue      = issue_w;
  assign hz.fwd_rs_sel = ev ? rs_sel : '0;
  assign hz.fwd_rt_sel = ev ? rt_sel : '0;
  assign hz.halted     = (state == HALTED);
  assign hz.dbg_state  = state;

  // The drain counter mirrors the HLT walking out of the slots; zero means the scoreboard is empty.
  always_comb begin
    state_nx     = state;
    drain_cnt_nx = drain_cnt;
    case (state)
      RUN: begin
        if (issue_w && hz.d_halt) begin
          state_nx     = DRAIN;
          drain_cnt_nx = SEL_W'(DEPTH);
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) state_nx = HALTED;
        else                 drain_cnt_nx = drain_cnt - SEL_W'(1);
      end
      HALTED:  state_nx = HALTED;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= '0;
      sq_cnt    <= 2'd0;
      for (int k = 0; k < DEPTH; k++) begin
        slot_v[k]  <= 1'b0;
        slot_rd[k] <= '0;
        slot_wr[k] <= 1'b0;
        slot_ld[k] <= 1'b0;
      end
    end else begin
      state     <= state_nx;
      drain_cnt <= drain_cnt_nx;
      // HLT occupies a slot but never produces a result.
      slot_v[0]  <= issue_w;
      slot_rd[0] <= issue_w ? hz.d_rd : '0;
      slot_wr[0] <= issue_w && hz.d_reg_write && !hz.d_halt;
      slot_ld[0] <= issue_w && hz.d_mem_read && !hz.d_halt;
      for (int k = 1; k < DEPTH; k++) begin
        slot_v[k]  <= slot_v[k-1];
        slot_rd[k] <= slot_rd[k-1];
        slot_wr[k] <= slot_wr[k-1];
        slot_ld[k] <= slot_ld[k-1];
      end
      if (issue_w && hz.d_branch)
        sq_cnt <= 2'(SQUASH_N);
      else if (sq_cnt != 2'd0 && hz.d_valid)
        sq_cnt <= sq_cnt - 2'd1;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scenario bench for hazard_scoreboard: u_dut1 uses SQUASH_N=1 and u_dut2 uses SQUASH_N=2.
// Both instances see identical decode stimulus.
module tb_hazard_scoreboard;
  typedef struct packed {
    logic       v;
    logic [3:0] rd;
    logic       wr;
    logic       ld;
    logic [3:0] rs;
    logic       rsu;
    logic [3:0] rt;
    logic       rtu;
    logic       halt;
    logic       br;
  } stim_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [7:0] exp_q [$];
  logic [7:0] exp2_q[$];

  hazard_if #(.REG_W(4), .DEPTH(3)) if1 ();
  hazard_if #(.REG_W(4), .DEPTH(3)) if2 ();

  hazard_scoreboard #(.REG_W(4), .DEPTH(3), .LOAD_LAT(1), .SQUASH_N(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .hz(if1)
  );
  hazard_scoreboard #(.REG_W(4), .DEPTH(3), .LOAD_LAT(1), .SQUASH_N(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .hz(if2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // stimulus helpers
  function automatic stim_t ins(input logic v, input logic [3:0] rd, input logic wr,
                                input logic ld, input logic [3:0] rs, input logic rsu,
                                input logic [3:0] rt, input logic rtu,
                                input logic halt, input logic br);
    stim_t s;
    s = '{v:v, rd:rd, wr:wr, ld:ld, rs:rs, rsu:rsu, rt:rt, rtu:rtu, halt:halt, br:br};
    return s;
  endfunction

  function automatic stim_t idle();
    return ins(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic stim_t alu(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
    return ins(1'b1, rd, 1'b1, 1'b0, rs, 1'b1, rt, 1'b1, 1'b0, 1'b0);
  endfunction

  // {stall, squash, issue, fwd_rs_sel, fwd_rt_sel, halted}
  function automatic logic [7:0] mk(input logic st, input logic sq, input logic is,
                                    input logic [1:0] rs, input logic [1:0] rt, input logic h);
    return {st, sq, is, rs, rt, h};
  endfunction

  function automatic logic [7:0] obs1();
    return {if1.stall, if1.squash, if1.issue, if1.fwd_rs_sel, if1.fwd_rt_sel, if1.halted};
  endfunction

  function automatic logic [7:0] obs2();
    return {if2.stall, if2.squash, if2.issue, if2.fwd_rs_sel, if2.fwd_rt_sel, if2.halted};
  endfunction

  // driver
  task automatic apply(input stim_t s);
    if1.d_valid = s.v;   if2.d_valid = s.v;
    if1.d_rd = s.rd;     if2.d_rd = s.rd;
    if1.d_reg_write = s.wr; if2.d_reg_write = s.wr;
    if1.d_mem_read = s.ld;  if2.d_mem_read = s.ld;
    if1.d_rs = s.rs;     if2.d_rs = s.rs;
    if1.d_rs_used = s.rsu; if2.d_rs_used = s.rsu;
    if1.d_rt = s.rt;     if2.d_rt = s.rt;
    if1.d_rt_used = s.rtu; if2.d_rt_used = s.rtu;
    if1.d_halt = s.halt; if2.d_halt = s.halt;
    if1.d_branch = s.br; if2.d_branch = s.br;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    logic [7:0] exp;
    rst_n = 1'b0;
    apply(idle());
    exp_q.push_back(mk(0, 0, 0, 2'd0, 2'd0, 0));
    exp2_q.push_back(mk(0, 0, 0, 2'd0, 2'd0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = obs1(); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reset_dut1 got=%b exp=%b", got, exp); end
    got = obs2(); exp = exp2_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reset_dut2 got=%b exp=%b", got, exp); end
    n_cmp++;
    if (if1.dbg_state !== 2'd0) begin
      n_err++; $display("FAIL reset_state got=%0d exp=0", if1.dbg_state);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    stim_t st[$];
    logic [7:0] ex[$];
    logic [7:0] got;
    logic [7:0] exp;
    st.push_back(alu(4'd3, 4'd1, 4'd2)); ex.push_back(mk(0, 0, 1, 2'd0, 2'd0, 0));
    st.push_back(alu(4'd5, 4'd3, 4'd3)); ex.push_back(mk(0, 0, 1, 2'd1, 2'd1, 0));
    st.push_back(alu(4'd6, 4'd5, 4'd3)); ex.push_back(mk(0, 0, 1, 2'd1, 2'd2, 0));
    st.push_back(ins(1'b0, 4'd0, 1'b0, 1'b0, 4'd6, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0));
    ex.push_back(mk(0, 0, 0, 2'd0, 2'd0, 0));
    st.push_back(idle()); ex.push_back(mk(0, 0, 0, 2'd0, 2'd0, 0));
    st.push_back(idle()); ex.push_back(mk(0, 0, 0, 2'd0, 2'd0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = obs1(); exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL forward[%0d] got=%b exp=%b", i, got, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t st[$];
    logic [7:0] ex[$];
    logic [7:0] got;
    logic [7:0] exp;
    st.push_back(ins(1'b1, 4'd2, 1'b1, 1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0));
    ex.push_back(mk(0, 0, 1, 2'd0, 2'd0, 0));
    st.push_back(alu(4'd4, 4'd2, 4'd1)); ex.push_back(mk(1, 0, 0, 2'd1, 2'd0, 0));
    st.push_back(alu(4'd4, 4'd2, 4'd1)); ex.push_back(mk(0, 0, 1, 2'd2, 2'd0, 0));
    st.push_back(alu(4'd5, 4'd4, 4'd2)); ex.push_back(mk(0, 0, 1, 2'd1, 2'd3, 0));
    repeat (3) begin st.push_back(idle()); ex.push_back(mk(0, 0, 0, 2'd0, 2'd0, 0)); end
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = obs1(); exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL load_use[%0d] got=%b exp=%b", i, got, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reg_zero();
    stim_t st[$];
    logic [7:0] ex[$];
    logic [7:0] got;
    logic [7:0] exp;
    st.push_back(alu(4'd0, 4'd1, 4'd1)); ex.push_back(mk(0, 0, 1, 2'd0, 2'd0, 0));
    st.push_back(alu(4'd2, 4'd0, 4'd0)); ex.push_back(mk(0, 0, 1, 2'd0, 2'd0, 0));
    st.push_back(ins(1'b1, 4'd7, 1'b1, 1'b0, 4'd2, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0));
    ex.push_back(mk(0, 0, 1, 2'd0, 2'd1, 0));
    st.push_back(ins(1'b1, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0));
    ex.push_back(mk(0, 0, 1, 2'd0, 2'd0, 0));
    st.push_back(alu(4'd8, 4'd0, 4'd0)); ex.push_back(mk(0, 0, 1, 2'd0, 2'd0, 0));
    repeat (3) begin st.push_back(idle()); ex.push_back(mk(0, 0, 0, 2'd0, 2'd0, 0)); end
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = obs1(); exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL reg_zero[%0d] got=%b exp=%b", i, got, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_youngest();
    stim_t st[$];
    logic [7:0] ex[$];
    logic [7:0] got;
    logic [7:0] exp;
    st.push_back(alu(4'd6, 4'd1, 4'd2)); ex.push_back(mk(0, 0, 1, 2'd0, 2'd0, 0));
    st.push_back(alu(4'd7, 4'd1, 4'd2)); ex.push_back(mk(0, 0, 1, 2'd0, 2'd0, 0));
    st.push_back(alu(4'd6, 4'd1, 4'd2)); ex.push_back(mk(0, 0, 1, 2'd0, 2'd0, 0));
    st.push_back(alu(4'd8, 4'd6, 4'd6)); ex.push_back(mk(0, 0, 1, 2'd1, 2'd1, 0));
    st.push_back(alu(4'd9, 4'd7, 4'd6)); ex.push_back(mk(0, 0, 1, 2'd3, 2'd2, 0));
    repeat (3) begin st.push_back(idle()); ex.push_back(mk(0, 0, 0, 2'd0, 2'd0, 0)); end
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = obs1(); exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL youngest[%0d] got=%b exp=%b", i, got, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_squash();
    stim_t st[$];
    logic [7:0] ex1[$];
    logic [7:0] ex2[$];
    logic [7:0] got;
    logic [7:0] exp;
    stim_t br_nosrc;
    stim_t hlt;
    stim_t add_nosrc;
    br_nosrc  = ins(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    hlt       = ins(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    add_nosrc = ins(1'b1, 4'd9, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    st.push_back(br_nosrc);  ex1.push_back(mk(0, 0, 1, 2'd0, 2'd0, 0)); ex2.push_back(mk(0, 0, 1, 2'd0, 2'd0, 0));
    st.push_back(hlt);       ex1.push_back(mk(0, 1, 0, 2'd0, 2'd0, 0)); ex2.push_back(mk(0, 1, 0, 2'd0, 2'd0, 0));
    st.push_back(idle());    ex1.push_back(mk(0, 0, 0, 2'd0, 2'd0, 0)); ex2.push_back(mk(0, 1, 0, 2'd0, 2'd0, 0));
    st.push_back(add_nosrc); ex1.push_back(mk(0, 0, 1, 2'd0, 2'd0, 0)); ex2.push_back(mk(0, 1, 0, 2'd0, 2'd0, 0));
    st.push_back(add_nosrc); ex1.push_back(mk(0, 0, 1, 2'd0, 2'd0, 0)); ex2.push_back(mk(0, 0, 1, 2'd0, 2'd0, 0));
    st.push_back(ins(1'b1, 4'd2, 1'b1, 1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0));
    ex1.push_back(mk(0, 0, 1, 2'd0, 2'd0, 0)); ex2.push_back(mk(0, 0, 1, 2'd0, 2'd0, 0));
    st.push_back(ins(1'b1, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1));
    ex1.push_back(mk(1, 0, 0, 2'd1, 2'd0, 0)); ex2.push_back(mk(1, 0, 0, 2'd1, 2'd0, 0));
    st.push_back(ins(1'b1, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1));
    ex1.push_back(mk(0, 0, 1, 2'd2, 2'd0, 0)); ex2.push_back(mk(0, 0, 1, 2'd2, 2'd0, 0));
    st.push_back(add_nosrc); ex1.push_back(mk(0, 1, 0, 2'd0, 2'd0, 0)); ex2.push_back(mk(0, 1, 0, 2'd0, 2'd0, 0));
    st.push_back(add_nosrc); ex1.push_back(mk(0, 0, 1, 2'd0, 2'd0, 0)); ex2.push_back(mk(0, 1, 0, 2'd0, 2'd0, 0));
    repeat (3) begin
      st.push_back(idle()); ex1.push_back(mk(0, 0, 0, 2'd0, 2'd0, 0)); ex2.push_back(mk(0, 0, 0, 2'd0, 2'd0, 0));
    end
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(ex1[i]);
      exp2_q.push_back(ex2[i]);
      @(negedge clk);
      got = obs1(); exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL squash1[%0d] got=%b exp=%b", i, got, exp); end
      got = obs2(); exp = exp2_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL squash2[%0d] got=%b exp=%b", i, got, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    stim_t st[$];
    logic [7:0] ex[$];
    logic [7:0] got;
    logic [7:0] exp;
    stim_t hlt;
    hlt = ins(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    st.push_back(hlt); ex.push_back(mk(0, 0, 1, 2'd0, 2'd0, 0));
    repeat (4) begin st.push_back(alu(4'd4, 4'd3, 4'd3)); ex.push_back(mk(1, 0, 0, 2'd0, 2'd0, 0)); end
    repeat (2) begin st.push_back(alu(4'd4, 4'd3, 4'd3)); ex.push_back(mk(1, 0, 0, 2'd0, 2'd0, 1)); end
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = obs1(); exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL halt[%0d] got=%b exp=%b", i, got, exp); end
      @(posedge clk); #1;
    end
    // reset out of HALTED
    apply(idle());
    rst_n = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 2'd0, 2'd0, 0));
    #2;
    got = obs1(); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL halt_reset got=%b exp=%b", got, exp); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_drain();
    stim_t st[$];
    logic [7:0] ex[$];
    logic [7:0] got;
    logic [7:0] exp;
    st.push_back(ins(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0));
    ex.push_back(mk(0, 0, 1, 2'd0, 2'd0, 0));
    st.push_back(idle()); ex.push_back(mk(1, 0, 0, 2'd0, 2'd0, 0));
    st.push_back(idle()); ex.push_back(mk(1, 0, 0, 2'd0, 2'd0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = obs1(); exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL drain[%0d] got=%b exp=%b", i, got, exp); end
      if (i < st.size() - 1) begin @(posedge clk); #1; end
    end
    rst_n = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 2'd0, 2'd0, 0));
    #1;
    got = obs1(); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL drain_reset got=%b exp=%b", got, exp); end
    n_cmp++;
    if (if1.dbg_state !== 2'd0) begin
      n_err++; $display("FAIL drain_reset_state got=%0d exp=0", if1.dbg_state);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    st.delete();
    ex.delete();
    st.push_back(ins(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    ex.push_back(mk(0, 0, 1, 2'd0, 2'd0, 0));
    st.push_back(alu(4'd6, 4'd5, 4'd1)); ex.push_back(mk(0, 0, 1, 2'd1, 2'd0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = obs1(); exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL after_reset[%0d] got=%b exp=%b", i, got, exp); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    apply(idle());
    test_reset();
    test_forward();
    test_load_use();
    test_reg_zero();
    test_youngest();
    test_squash();
    test_halt();
    test_reset_mid_drain();
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size() + exp2_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
